// File: rtl/range_session_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | range_session_arbiter_if                                                 |
// | Requester, range-finder and result signals of the session arbiter.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface range_session_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int CW    = 8
) ();
    localparam int c_IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       s_valid;
    logic [NREQ-1:0]       s_last;
    logic [NREQ*WIDTH-1:0] s_data;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic                  rf_go;
    logic                  rf_finish;
    logic [WIDTH-1:0]      rf_data;
    logic [WIDTH-1:0]      rf_range;
    logic                  rf_error;
    logic                  res_valid;
    logic [c_IDW-1:0]      res_id;
    logic [WIDTH-1:0]      res_range;
    logic [CW-1:0]         res_count;
    logic                  res_abort;
    logic                  err;

    modport master (
        output req, s_valid, s_last, s_data, rf_range, rf_error,
        input  grant, busy, rf_go, rf_finish, rf_data,
               res_valid, res_id, res_range, res_count, res_abort, err
    );

    modport slave (
        input  req, s_valid, s_last, s_data, rf_range, rf_error,
        output grant, busy, rf_go, rf_finish, rf_data,
               res_valid, res_id, res_range, res_count, res_abort, err
    );
endinterface
`default_nettype wire

// File: rtl/range_session_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | range_session_arbiter                                                    |
// | Round-robin sharing of one range finder between NREQ sample producers.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module range_session_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int CW    = 8
) (
    input  wire logic                   clock,
    input  wire logic                   reset,
    range_session_arbiter_if.slave      bus
);
    localparam int c_IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        ST_ARB     = 3'd0,
        ST_GRANT   = 3'd1,
        ST_STREAM  = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_CAPTURE = 3'd4
    } state_t;

    state_t           r_state;
    logic [NREQ-1:0]  r_grant;
    logic [c_IDW-1:0] r_ptr;
    logic [WIDTH-1:0] r_held;
    logic [CW-1:0]    r_count;
    logic             r_abort;
    logic             r_res_valid;
    logic [c_IDW-1:0] r_res_id;
    logic [WIDTH-1:0] r_res_range;
    logic [CW-1:0]    r_res_count;
    logic             r_res_abort;
    logic             r_err;

    logic             w_sel_valid;
    logic             w_sel_last;
    logic             w_sel_req;
    logic [WIDTH-1:0] w_sel_data;
    logic [c_IDW-1:0] w_scan;
    logic [c_IDW-1:0] w_next_idx;
    logic             w_found;
    logic [CW-1:0]    w_count_inc;
    logic             w_rf_go;
    logic             w_rf_finish;
    logic [WIDTH-1:0] w_rf_data;

    assign w_sel_valid = |(bus.s_valid & r_grant);
    assign w_sel_last  = |(bus.s_valid & bus.s_last & r_grant);
    assign w_sel_req   = |(bus.req & r_grant);
    assign w_count_inc = (r_count == {CW{1'b1}}) ? r_count : r_count + CW'(1);

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant[i]) begin
                w_sel_data = w_sel_data | bus.s_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Scan ptr+1, ptr+2, ... with wrap so the last winner has lowest priority.
    always_comb begin
        w_scan     = r_ptr;
        w_next_idx = '0;
        w_found    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan = (w_scan == c_IDW'(NREQ - 1)) ? '0 : w_scan + c_IDW'(1);
            if (!w_found && bus.req[w_scan]) begin
                w_found    = 1'b1;
                w_next_idx = w_scan;
            end
        end
    end

    // Idle stream cycles replay the held sample so min/max stay unchanged.
    always_comb begin
        w_rf_go     = 1'b0;
        w_rf_finish = 1'b0;
        w_rf_data   = r_held;
        case (r_state)
            ST_GRANT: begin
                w_rf_go = w_sel_valid;
                if (w_sel_valid) w_rf_data = w_sel_data;
            end
            ST_STREAM: begin
                if (w_sel_valid) w_rf_data = w_sel_data;
                w_rf_finish = (w_sel_valid && w_sel_last) || !w_sel_req;
            end
            ST_FLUSH: w_rf_finish = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_ARB;
            r_grant     <= '0;
            r_ptr       <= c_IDW'(NREQ - 1);
            r_held      <= '0;
            r_count     <= '0;
            r_abort     <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_range <= '0;
            r_res_count <= '0;
            r_res_abort <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            if (bus.rf_error) r_err <= 1'b1;
            case (r_state)
                ST_ARB: begin
                    if (w_found) begin
                        r_grant <= {{(NREQ-1){1'b0}}, 1'b1} << w_next_idx;
                        r_ptr   <= w_next_idx;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_sel_valid) begin
                        r_held  <= w_sel_data;
                        r_count <= CW'(1);
                        r_state <= w_sel_last ? ST_FLUSH : ST_STREAM;
                    end else if (!w_sel_req) begin
                        r_grant <= '0;
                        r_state <= ST_ARB;
                    end
                end
                ST_STREAM: begin
                    if (w_sel_valid) begin
                        r_held  <= w_sel_data;
                        r_count <= w_count_inc;
                    end
                    if (w_sel_valid && w_sel_last) begin
                        r_state <= ST_CAPTURE;
                    end else if (!w_sel_req) begin
                        r_abort <= 1'b1;
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_FLUSH: r_state <= ST_CAPTURE;
                ST_CAPTURE: begin
                    r_res_valid <= 1'b1;
                    r_res_id    <= r_ptr;
                    r_res_range <= bus.rf_range;
                    r_res_count <= r_count;
                    r_res_abort <= r_abort;
                    r_abort     <= 1'b0;
                    r_grant     <= '0;
                    r_state     <= ST_ARB;
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end

    assign bus.grant     = r_grant;
    assign bus.busy      = (r_state != ST_ARB);
    assign bus.rf_go     = w_rf_go;
    assign bus.rf_finish = w_rf_finish;
    assign bus.rf_data   = w_rf_data;
    assign bus.res_valid = r_res_valid;
    assign bus.res_id    = r_res_id;
    assign bus.res_range = r_res_range;
    assign bus.res_count = r_res_count;
    assign bus.res_abort = r_res_abort;
    assign bus.err       = r_err;
endmodule
`default_nettype wire

// File: tb/tb_range_session_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_range_session_arbiter                                                 |
// | Directed sessions against a min/max range-finder model, scoreboarded.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_range_session_arbiter;
    localparam int WIDTH = 16;
    localparam int NREQ  = 4;
    localparam int CW    = 8;

    typedef struct {
        int id;
        int range;
        int count;
        int abort;
    } exp_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    int   n_results;
    int   n_expected;
    exp_t exp_q[$];

    logic             cap_go;
    logic             cap_fin;
    logic [WIDTH-1:0] cap_data;

    range_session_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .CW(CW)) bus ();

    range_session_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .CW(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Range-finder model: go loads min/max, finish moves to FINISH for one cycle.
    logic [1:0]       m_st;
    logic [WIDTH-1:0] m_mn;
    logic [WIDTH-1:0] m_mx;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_st <= 2'd0;
            m_mn <= '0;
            m_mx <= '0;
        end else begin
            case (m_st)
                2'd0: if (bus.rf_go) begin
                    m_mn <= bus.rf_data;
                    m_mx <= bus.rf_data;
                    m_st <= 2'd1;
                end
                2'd1: begin
                    if (bus.rf_data < m_mn) m_mn <= bus.rf_data;
                    if (bus.rf_data > m_mx) m_mx <= bus.rf_data;
                    if (bus.rf_finish) m_st <= 2'd2;
                end
                default: m_st <= 2'd0;
            endcase
        end
    end
    assign bus.rf_range = m_mx - m_mn;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req_v);
        end
    endtask

    // Monitor: one-hot grant, protocol sanity, and scoreboard pops.
    always @(negedge clock) begin
        if (!reset) begin
            chk("grant_onehot", ($countones(bus.grant) <= 1) ? 1 : 0, 1);
            if (bus.rf_go && (bus.rf_finish || m_st != 2'd0)) begin
                errors++;
                $display("FAIL rf_go_protocol go=%0d finish=%0d model_state=%0d", bus.rf_go, bus.rf_finish, m_st);
            end
            if (bus.res_valid) begin
                n_results++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result id=%0d range=%0d", bus.res_id, bus.res_range);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("res_id",    32'(bus.res_id),    e.id);
                    chk("res_range", 32'(bus.res_range), e.range);
                    chk("res_count", 32'(bus.res_count), e.count);
                    chk("res_abort", 32'(bus.res_abort), e.abort);
                end
            end
        end
    end

    task automatic expect_res(input int id, input int range, input int count, input int abort);
        exp_q.push_back('{id, range, count, abort});
        n_expected++;
    endtask

    task automatic wait_grant(input int r);
        int n;
        n = 0;
        while (bus.grant != '0 && n < 20) begin
            @(posedge clock); #1; n++;
        end
        n = 0;
        while (bus.grant == '0 && n < 40) begin
            @(posedge clock); #1; n++;
        end
        chk("grant_owner", 32'(bus.grant), 32'(1) << r);
    endtask

    task automatic beat(input int r, input logic [WIDTH-1:0] d, input bit last);
        bus.s_valid[r] = 1'b1;
        bus.s_last[r]  = last;
        bus.s_data[r*WIDTH +: WIDTH] = d;
        @(negedge clock);
        cap_go = bus.rf_go; cap_fin = bus.rf_finish; cap_data = bus.rf_data;
        @(posedge clock); #1;
        bus.s_valid[r] = 1'b0;
        bus.s_last[r]  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clock);
        cap_go = bus.rf_go; cap_fin = bus.rf_finish; cap_data = bus.rf_data;
        @(posedge clock); #1;
    endtask

    task automatic settle();
        int n;
        n = 0;
        while ((bus.busy || exp_q.size() != 0) && n < 30) begin
            @(posedge clock); #1; n++;
        end
        chk("settle_queue", 32'(exp_q.size()), 0);
    endtask

    int t2_d0[4]  = '{3, 20, 7, 100};
    int t2_d1[4]  = '{11, 5, 7, 60};
    int t2_rng[4] = '{8, 15, 0, 40};

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        checks = 0; errors = 0; n_results = 0; n_expected = 0;
        reset = 1'b1;
        bus.req = '0; bus.s_valid = '0; bus.s_last = '0; bus.s_data = '0;
        bus.rf_error = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_res_valid", 32'(bus.res_valid), 0);
        chk("rst_res_count", 32'(bus.res_count), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_rf_go", 32'(bus.rf_go), 0);
        chk("rst_rf_data", 32'(bus.rf_data), 0);

        // Two contenders present out of reset: expect 0,2,0,2.
        bus.req = 4'b0101;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            int r;
            r = (k % 2 == 0) ? 0 : 2;
            expect_res(r, t2_rng[k], 2, 0);
            wait_grant(r);
            beat(r, WIDTH'(t2_d0[k]), 1'b0);
            beat(r, WIDTH'(t2_d1[k]), 1'b1);
            if (k >= 2) bus.req[r] = 1'b0;
        end
        settle();

        // Four-beat burst; result two cycles after the last beat.
        bus.req[1] = 1'b1;
        expect_res(1, 7, 4, 0);
        wait_grant(1);
        beat(1, 16'd5, 1'b0);
        chk("t1_go", 32'(cap_go), 1);
        chk("t1_go_data", 32'(cap_data), 5);
        beat(1, 16'd9, 1'b0);
        beat(1, 16'd2, 1'b0);
        beat(1, 16'd7, 1'b1);
        chk("t1_finish", 32'(cap_fin), 1);
        bus.req[1] = 1'b0;
        @(negedge clock);
        chk("t1_lat_t1", 32'(bus.res_valid), 0);
        @(negedge clock);
        chk("t1_lat_t2", 32'(bus.res_valid), 1);
        chk("t1_grant_off", 32'(bus.grant), 0);
        settle();

        // Single-beat session goes through FLUSH.
        bus.req[3] = 1'b1;
        expect_res(3, 0, 1, 0);
        wait_grant(3);
        beat(3, 16'd42, 1'b1);
        chk("t3_go", 32'(cap_go), 1);
        chk("t3_no_fin_with_go", 32'(cap_fin), 0);
        bus.req[3] = 1'b0;
        idle_cycle();
        chk("t3_flush_fin", 32'(cap_fin), 1);
        chk("t3_flush_go", 32'(cap_go), 0);
        chk("t3_flush_data", 32'(cap_data), 42);
        settle();
        chk("t3_err", 32'(bus.err), 0);

        // Idle gaps replay the held sample; a non-granted beat is ignored.
        bus.req[0] = 1'b1;
        expect_res(0, 20, 3, 0);
        wait_grant(0);
        beat(0, 16'd10, 1'b0);
        bus.s_valid[1] = 1'b1;
        bus.s_data[1*WIDTH +: WIDTH] = 16'd99;
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            chk("t4_idle_data", 32'(cap_data), 10);
            chk("t4_idle_fin", 32'(cap_fin), 0);
        end
        bus.s_valid[1] = 1'b0;
        beat(0, 16'd30, 1'b0);
        beat(0, 16'd20, 1'b1);
        bus.req[0] = 1'b0;
        settle();

        // Requester drops out mid-burst: finish on the held sample, aborted.
        bus.req[2] = 1'b1;
        expect_res(2, 4, 2, 1);
        wait_grant(2);
        beat(2, 16'd4, 1'b0);
        beat(2, 16'd8, 1'b0);
        bus.req[2] = 1'b0;
        idle_cycle();
        chk("t5_abort_fin", 32'(cap_fin), 1);
        chk("t5_abort_data", 32'(cap_data), 8);
        settle();

        // Sticky error flag.
        bus.rf_error = 1'b1;
        @(posedge clock); #1;
        bus.rf_error = 1'b0;
        @(negedge clock);
        chk("err_set", 32'(bus.err), 1);
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("err_sticky", 32'(bus.err), 1);
        @(posedge clock); #1;

        // Beat count saturates at 2**CW-1.
        bus.req[3] = 1'b1;
        expect_res(3, 95, 255, 0);
        wait_grant(3);
        for (int i = 0; i < 260; i++) begin
            beat(3, (i == 0) ? 16'd5 : 16'd100, (i == 259));
        end
        bus.req[3] = 1'b0;
        settle();

        // Reset mid-stream abandons the session without a result.
        bus.req[1] = 1'b1;
        wait_grant(1);
        beat(1, 16'd3, 1'b0);
        beat(1, 16'd50, 1'b0);
        reset = 1'b1;
        bus.req[1] = 1'b0;
        @(negedge clock);
        chk("t6_grant", 32'(bus.grant), 0);
        chk("t6_busy", 32'(bus.busy), 0);
        chk("t6_err", 32'(bus.err), 0);
        chk("t6_res_valid", 32'(bus.res_valid), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        bus.req[1] = 1'b1;
        expect_res(1, 5, 2, 0);
        wait_grant(1);
        beat(1, 16'd6, 1'b0);
        beat(1, 16'd1, 1'b1);
        bus.req[1] = 1'b0;
        settle();

        repeat (5) @(posedge clock);
        chk("results_seen", 32'(n_results), 32'(n_expected));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
